// File: rtl/mem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_if
// Purpose : SRAM-like data port with request / address-accept / data-return
//           handshake, shared by the memory access controller and the memory.
// Signals : data_sram_req     request valid (held with stable fields until addr_ok)
//           data_sram_wr      1 = write, 0 = read
//           data_sram_size    0 = byte, 1 = half, 2 = word
//           data_sram_wstrb   byte strobes (0 on reads)
//           data_sram_addr    request address
//           data_sram_wdata   lane-replicated store data
//           data_sram_addr_ok memory accepted the request this cycle
//           data_sram_data_ok response valid this cycle
//           data_sram_rdata   read data, valid with data_ok
// Handshake: a request transfers on a cycle where req && addr_ok; exactly one
//           data_ok follows for it (possibly in the same cycle as addr_ok).
// Modports: master = controller side, slave = memory side.
// -----------------------------------------------------------------------------
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              data_sram_req;
    logic              data_sram_wr;
    logic [1:0]        data_sram_size;
    logic [3:0]        data_sram_wstrb;
    logic [ADDR_W-1:0] data_sram_addr;
    logic [DATA_W-1:0] data_sram_wdata;
    logic              data_sram_addr_ok;
    logic              data_sram_data_ok;
    logic [DATA_W-1:0] data_sram_rdata;

    modport master (
        output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );

    modport slave (
        input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
        output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Purpose : Sequences loads/stores between the EX and ME pipeline stages over
//           the SRAM-like data port. Builds byte strobes and replicated store
//           data on the request side, aligns and extends load data on the
//           return side, and gives ME a ready signal so memory latency stalls
//           the pipeline.
// Ports   : clk, reset        clock, synchronous active-high reset
//           ex_*              access presented by EX (valid, mem_en, we, size,
//                             load_sext, addr, wdata)
//           ctrl_allowin      controller accepts a new access this cycle
//           sram              data port (mem_access_ctrl_if.master)
//           wb_allowin        WB stage accepts the ME result
//           me_ready_go       ME result complete
//           me_load_result    aligned, extended load data
//           mem_ale           misaligned-access flag (only with MEM_ALE_CHECK_EN)
//           dbg_state         FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 DONE)
// Option  : `define MEM_ALE_CHECK_EN to trap misaligned half/word accesses.
//           Without it, misaligned accesses issue with truncated strobes.
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_mem_en,
    input  logic              ex_mem_we,
    input  logic [1:0]        ex_mem_size,
    input  logic              ex_load_sext,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              ctrl_allowin,
    mem_access_ctrl_if.master sram,
    input  logic              wb_allowin,
    output logic              me_ready_go,
    output logic [DATA_W-1:0] me_load_result,
    output logic              mem_ale,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              sext_q;
    logic [3:0]        wstrb_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] load_q;

    logic              accept;
    logic              mis_acc;
    logic              capture_rd;
    logic [3:0]        acc_wstrb;
    logic [DATA_W-1:0] acc_wdata;
    logic [DATA_W-1:0] rd_shift;
    logic [DATA_W-1:0] rd_aligned;

    assign accept = ex_valid && ex_mem_en && ctrl_allowin;

`ifdef MEM_ALE_CHECK_EN
    // Size 3 is treated as a word everywhere, so it is checked like one.
    assign mis_acc = ((ex_mem_size == 2'd1) && ex_addr[0]) ||
                     (ex_mem_size[1] && (ex_addr[1:0] != 2'd0));
`else
    assign mis_acc = 1'b0;
`endif

    // Read data is taken on data_ok in WAIT, or in REQ when addr_ok and
    // data_ok coincide. data_ok in IDLE/DONE belongs to nothing and is dropped.
    assign capture_rd = ((state_q == S_REQ) && sram.data_sram_addr_ok && sram.data_sram_data_ok) ||
                        ((state_q == S_WAIT) && sram.data_sram_data_ok);

    // Request-side strobes and lane replication from the presented access.
    // The 4-bit shift truncates strobes of misaligned halves on purpose.
    always_comb begin
        acc_wstrb = 4'hF;
        acc_wdata = ex_wdata;
        case (ex_mem_size)
            2'd0: begin
                acc_wstrb = 4'b0001 << ex_addr[1:0];
                acc_wdata = {4{ex_wdata[7:0]}};
            end
            2'd1: begin
                acc_wstrb = 4'b0011 << ex_addr[1:0];
                acc_wdata = {2{ex_wdata[15:0]}};
            end
            default: begin
                acc_wstrb = 4'hF;
                acc_wdata = ex_wdata;
            end
        endcase
        if (!ex_mem_we) begin
            acc_wstrb = 4'h0;
        end
    end

    // Return-side alignment: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        rd_shift   = sram.data_sram_rdata >> {addr_q[1:0], 3'b000};
        rd_aligned = rd_shift;
        case (size_q)
            2'd0:    rd_aligned = {{24{sext_q & rd_shift[7]}},  rd_shift[7:0]};
            2'd1:    rd_aligned = {{16{sext_q & rd_shift[15]}}, rd_shift[15:0]};
            default: rd_aligned = rd_shift;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = mis_acc ? S_DONE : S_REQ;
            S_REQ:  if (sram.data_sram_addr_ok) state_d = sram.data_sram_data_ok ? S_DONE : S_WAIT;
            S_WAIT: if (sram.data_sram_data_ok) state_d = S_DONE;
            S_DONE: begin
                // accept in DONE already implies wb_allowin
                if (wb_allowin) state_d = accept ? (mis_acc ? S_DONE : S_REQ) : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ctrl_allowin         = (state_q == S_IDLE) || ((state_q == S_DONE) && wb_allowin);
        me_ready_go          = (state_q == S_DONE) ||
                               ((state_q == S_IDLE) && ex_valid && !ex_mem_en);
        sram.data_sram_req   = (state_q == S_REQ);
        sram.data_sram_wr    = we_q;
        sram.data_sram_size  = size_q;
        sram.data_sram_wstrb = wstrb_q;
        sram.data_sram_addr  = addr_q;
        sram.data_sram_wdata = wdata_q;
        me_load_result       = load_q;
        dbg_state            = state_q;
    end

    // Request fields and load result
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            size_q  <= 2'd0;
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            wstrb_q <= 4'h0;
            wdata_q <= '0;
            load_q  <= '0;
        end else begin
            if (accept) begin
                addr_q  <= ex_addr;
                size_q  <= ex_mem_size;
                we_q    <= ex_mem_we;
                sext_q  <= ex_load_sext;
                wstrb_q <= acc_wstrb;
                wdata_q <= acc_wdata;
            end
            if (capture_rd && !we_q) begin
                load_q <= rd_aligned;
            end
        end
    end

`ifdef MEM_ALE_CHECK_EN
    logic ale_q;

    // Set by a misaligned acceptance, cleared when DONE is left.
    always_ff @(posedge clk) begin
        if (reset) begin
            ale_q <= 1'b0;
        end else if (accept) begin
            ale_q <= mis_acc;
        end else if ((state_q == S_DONE) && wb_allowin) begin
            ale_q <= 1'b0;
        end
    end

    assign mem_ale = ale_q;
`else
    assign mem_ale = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              ex_valid;
    logic              ex_mem_en;
    logic              ex_mem_we;
    logic [1:0]        ex_mem_size;
    logic              ex_load_sext;
    logic [ADDR_W-1:0] ex_addr;
    logic [DATA_W-1:0] ex_wdata;
    logic              ctrl_allowin;
    logic              wb_allowin;
    logic              me_ready_go;
    logic [DATA_W-1:0] me_load_result;
    logic              mem_ale;
    logic [1:0]        dbg_state;

    mem_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sram_if ();

    mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_mem_en      (ex_mem_en),
        .ex_mem_we      (ex_mem_we),
        .ex_mem_size    (ex_mem_size),
        .ex_load_sext   (ex_load_sext),
        .ex_addr        (ex_addr),
        .ex_wdata       (ex_wdata),
        .ctrl_allowin   (ctrl_allowin),
        .sram           (sram_if),
        .wb_allowin     (wb_allowin),
        .me_ready_go    (me_ready_go),
        .me_load_result (me_load_result),
        .mem_ale        (mem_ale),
        .dbg_state      (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [DATA_W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference load alignment, written lane by lane.
    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] size,
                                               input logic [1:0] a, input logic sext);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0: b = rd[7:0];
            2'd1: b = rd[15:8];
            2'd2: b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (size)
            2'd0:    model_load = sext ? {{24{b[7]}}, b}  : {24'h0, b};
            2'd1:    model_load = sext ? {{16{h[15]}}, h} : {16'h0, h};
            default: model_load = rd;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic we, input logic [1:0] size, input logic sext,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic push, input logic [31:0] exp_res);
        ex_valid     = 1'b1;
        ex_mem_en    = 1'b1;
        ex_mem_we    = we;
        ex_mem_size  = size;
        ex_load_sext = sext;
        ex_addr      = addr;
        ex_wdata     = wdata;
        if (push) exp_q.push_back(exp_res);
    endtask

    task automatic drop_ex();
        ex_valid  = 1'b0;
        ex_mem_en = 1'b0;
    endtask

    // Starts with the DUT in REQ, ends with it in DONE. d_lat < 0 means
    // data_ok arrives together with addr_ok.
    task automatic serve(input string tag, input int a_lat, input int d_lat,
                         input logic [31:0] rdata, input logic [31:0] exp_addr,
                         input logic exp_we, input logic [1:0] exp_size,
                         input logic [3:0] exp_strb, input logic [31:0] exp_wd);
        int reqs = 0;
        for (int i = 0; i < a_lat; i++) begin
            sram_if.data_sram_rdata = $urandom;
            #1;
            check({tag, ".req_hold"}, 32'(sram_if.data_sram_req), 32'd1);
            check({tag, ".addr_hold"}, sram_if.data_sram_addr, exp_addr);
            if (sram_if.data_sram_req) reqs++;
            step();
        end
        sram_if.data_sram_addr_ok = 1'b1;
        if (d_lat < 0) begin
            sram_if.data_sram_data_ok = 1'b1;
            sram_if.data_sram_rdata   = rdata;
        end
        #1;
        if (sram_if.data_sram_req) reqs++;
        check({tag, ".addr"},  sram_if.data_sram_addr, exp_addr);
        check({tag, ".wr"},    32'(sram_if.data_sram_wr), 32'(exp_we));
        check({tag, ".size"},  32'(sram_if.data_sram_size), 32'(exp_size));
        check({tag, ".wstrb"}, 32'(sram_if.data_sram_wstrb), 32'(exp_strb));
        check({tag, ".wdata"}, sram_if.data_sram_wdata, exp_wd);
        step();
        sram_if.data_sram_addr_ok = 1'b0;
        sram_if.data_sram_data_ok = 1'b0;
        if (d_lat >= 0) begin
            check({tag, ".state_wait"}, 32'(dbg_state), 32'(ST_WAIT));
            for (int i = 0; i < d_lat; i++) begin
                sram_if.data_sram_rdata = $urandom;
                #1;
                check({tag, ".req_low"}, 32'(sram_if.data_sram_req), 32'd0);
                step();
            end
            sram_if.data_sram_data_ok = 1'b1;
            sram_if.data_sram_rdata   = rdata;
            step();
            sram_if.data_sram_data_ok = 1'b0;
            sram_if.data_sram_rdata   = $urandom;
        end
        check({tag, ".req_cycles"}, 32'(reqs), 32'(a_lat + 1));
        check({tag, ".state_done"}, 32'(dbg_state), 32'(ST_DONE));
        check({tag, ".ready_go"}, 32'(me_ready_go), 32'd1);
        if (!exp_we) begin
            if (exp_q.size() != 0) begin
                check({tag, ".result"}, me_load_result, exp_q.pop_front());
            end else begin
                total++;
                bad++;
                $display("FAIL %s.scoreboard observed=no_expected_entry expected=entry", tag);
            end
        end
    endtask

    task automatic finish_idle(input string tag);
        step();
        check({tag, ".state_idle"}, 32'(dbg_state), 32'(ST_IDLE));
        check({tag, ".ready_low"}, 32'(me_ready_go), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] rd;
        logic [31:0] addr;
        logic [1:0]  sz;
        logic        sx;

        reset = 1'b1;
        wb_allowin = 1'b1;
        drop_ex();
        ex_mem_we = 1'b0; ex_mem_size = 2'd0; ex_load_sext = 1'b0;
        ex_addr = '0; ex_wdata = '0;
        sram_if.data_sram_addr_ok = 1'b0;
        sram_if.data_sram_data_ok = 1'b0;
        sram_if.data_sram_rdata   = '0;
        step();
        step();
        check("rst.state",  32'(dbg_state), 32'(ST_IDLE));
        check("rst.req",    32'(sram_if.data_sram_req), 32'd0);
        check("rst.ready",  32'(me_ready_go), 32'd0);
        check("rst.result", me_load_result, 32'd0);
        check("rst.ale",    32'(mem_ale), 32'd0);
        check("rst.wstrb",  32'(sram_if.data_sram_wstrb), 32'd0);
        check("rst.addr",   sram_if.data_sram_addr, 32'd0);
        reset = 1'b0;
        step();

        // non-memory instruction passes straight through IDLE
        ex_valid = 1'b1; ex_mem_en = 1'b0;
        #1;
        check("nonmem.ready",   32'(me_ready_go), 32'd1);
        check("nonmem.allowin", 32'(ctrl_allowin), 32'd1);
        step();
        check("nonmem.state", 32'(dbg_state), 32'(ST_IDLE));
        check("nonmem.req",   32'(sram_if.data_sram_req), 32'd0);
        drop_ex();
        #1;
        check("nonmem.ready_off", 32'(me_ready_go), 32'd0);

        // word load
        present(1'b0, 2'd2, 1'b0, 32'h0000_1000, 32'h0, 1'b1, 32'h8899_AABB);
        #1;
        check("ldw.allowin", 32'(ctrl_allowin), 32'd1);
        step();
        drop_ex();
        serve("ldw", 2, 2, 32'h8899_AABB, 32'h0000_1000, 1'b0, 2'd2, 4'h0, 32'h0);
        finish_idle("ldw");

        // byte store to the top lane
        present(1'b1, 2'd0, 1'b0, 32'h0000_2003, 32'h0000_00A5, 1'b0, 32'h0);
        step();
        drop_ex();
        serve("stb", 1, 0, 32'hFFFF_FFFF, 32'h0000_2003, 1'b1, 2'd0, 4'b1000, 32'hA5A5_A5A5);
        check("stb.result_kept", me_load_result, 32'h8899_AABB);
        finish_idle("stb");

        // half loads, signed with addr_ok/data_ok coincident, then unsigned
        present(1'b0, 2'd1, 1'b1, 32'h0000_3002, 32'h0, 1'b1, 32'hFFFF_80FF);
        step();
        drop_ex();
        serve("ldh", 0, -1, 32'h80FF_1234, 32'h0000_3002, 1'b0, 2'd1, 4'h0, 32'h0);
        finish_idle("ldh");
        present(1'b0, 2'd1, 1'b0, 32'h0000_3002, 32'h0, 1'b1, 32'h0000_80FF);
        step();
        drop_ex();
        serve("ldhu", 0, 1, 32'h80FF_1234, 32'h0000_3002, 1'b0, 2'd1, 4'h0, 32'h0);
        finish_idle("ldhu");

        // half and word stores
        present(1'b1, 2'd1, 1'b0, 32'h0000_3002, 32'hDEAD_BEEF, 1'b0, 32'h0);
        step();
        drop_ex();
        serve("sth", 1, 1, 32'h0, 32'h0000_3002, 1'b1, 2'd1, 4'b1100, 32'hBEEF_BEEF);
        finish_idle("sth");
        present(1'b1, 2'd2, 1'b0, 32'h0000_3000, 32'hCAFE_F00D, 1'b0, 32'h0);
        step();
        drop_ex();
        serve("stw", 0, 0, 32'h0, 32'h0000_3000, 1'b1, 2'd2, 4'hF, 32'hCAFE_F00D);
        finish_idle("stw");

        // WB stall in DONE, then back-to-back acceptance out of DONE
        present(1'b0, 2'd0, 1'b1, 32'h0000_6001, 32'h0, 1'b1, 32'hFFFF_FF80);
        step();
        drop_ex();
        serve("ldb", 1, 0, 32'h0000_8000, 32'h0000_6001, 1'b0, 2'd0, 4'h0, 32'h0);
        wb_allowin = 1'b0;
        present(1'b0, 2'd2, 1'b0, 32'h0000_7000, 32'h0, 1'b1, 32'h1357_9BDF);
        #1;
        check("stall.allowin", 32'(ctrl_allowin), 32'd0);
        step();
        check("stall.state", 32'(dbg_state), 32'(ST_DONE));
        check("stall.req",   32'(sram_if.data_sram_req), 32'd0);
        check("stall.ready", 32'(me_ready_go), 32'd1);
        wb_allowin = 1'b1;
        #1;
        check("b2b.allowin", 32'(ctrl_allowin), 32'd1);
        step();
        drop_ex();
        check("b2b.state_req", 32'(dbg_state), 32'(ST_REQ));
        serve("b2b", 0, 0, 32'h1357_9BDF, 32'h0000_7000, 1'b0, 2'd2, 4'h0, 32'h0);
        finish_idle("b2b");

        // random aligned loads
        for (int n = 0; n < 6; n++) begin
            sz   = 2'($urandom_range(0, 2));
            sx   = 1'($urandom_range(0, 1));
            rd   = $urandom;
            addr = 32'h0000_8000 + 32'($urandom_range(0, 255)) * 4;
            if (sz == 2'd0) addr = addr + 32'($urandom_range(0, 3));
            if (sz == 2'd1) addr = addr + 32'($urandom_range(0, 1)) * 2;
            present(1'b0, sz, sx, addr, 32'h0, 1'b1, model_load(rd, sz, addr[1:0], sx));
            step();
            drop_ex();
            serve("rnd", $urandom_range(0, 2), $urandom_range(0, 3) - 1, rd, addr, 1'b0, sz, 4'h0, 32'h0);
            finish_idle("rnd");
        end

`ifdef MEM_ALE_CHECK_EN
        // misaligned word load is trapped without a request
        present(1'b0, 2'd2, 1'b0, 32'h0000_4002, 32'h0, 1'b0, 32'h0);
        #1;
        check("ale.req_pre", 32'(sram_if.data_sram_req), 32'd0);
        step();
        drop_ex();
        check("ale.state", 32'(dbg_state), 32'(ST_DONE));
        check("ale.req",   32'(sram_if.data_sram_req), 32'd0);
        check("ale.flag",  32'(mem_ale), 32'd1);
        check("ale.ready", 32'(me_ready_go), 32'd1);
        step();
        check("ale.state_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("ale.flag_clr",   32'(mem_ale), 32'd0);
`else
        // misaligned half store issues with truncated strobes
        present(1'b1, 2'd1, 1'b0, 32'h0000_5003, 32'h0000_1234, 1'b0, 32'h0);
        step();
        drop_ex();
        serve("mis", 0, 0, 32'h0, 32'h0000_5003, 1'b1, 2'd1, 4'b1000, 32'h1234_1234);
        check("mis.ale", 32'(mem_ale), 32'd0);
        finish_idle("mis");
`endif

        // reset while waiting for data; the late data_ok must be ignored
        present(1'b0, 2'd2, 1'b0, 32'h0000_9000, 32'h0, 1'b1, 32'h0);
        step();
        drop_ex();
        sram_if.data_sram_addr_ok = 1'b1;
        step();
        sram_if.data_sram_addr_ok = 1'b0;
        check("rstw.state_wait", 32'(dbg_state), 32'(ST_WAIT));
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        check("rstw.state_idle", 32'(dbg_state), 32'(ST_IDLE));
        check("rstw.req",        32'(sram_if.data_sram_req), 32'd0);
        step();
        step();
        sram_if.data_sram_data_ok = 1'b1;
        sram_if.data_sram_rdata   = 32'hFFFF_FFFF;
        step();
        sram_if.data_sram_data_ok = 1'b0;
        check("rstw.state_after", 32'(dbg_state), 32'(ST_IDLE));
        check("rstw.ready",       32'(me_ready_go), 32'd0);
        check("rstw.result",      me_load_result, 32'd0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
